// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: write-class bit indices,
// timeout counter width and the FSM state type.
package dmem_bridge_pkg;

  localparam int WE_SB = 0;
  localparam int WE_SH = 1;
  localparam int WE_SW = 2;
  localparam int TO_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: derives byte strobes, lane-replicated store data
// and the misalignment flag from the low address bits and the store class.
module dmem_lane_align
  import dmem_bridge_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr,
  input  logic [2:0]      we,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      strb,
  output logic [XLEN-1:0] wdata_aligned,
  output logic            misalign
);

  logic is_sw;
  logic is_sh;
  logic is_sb;

  // Word stores dominate halfword stores, which dominate byte stores.
  assign is_sw = we[WE_SW];
  assign is_sh = we[WE_SH] & ~we[WE_SW];
  assign is_sb = we[WE_SB] & ~we[WE_SH] & ~we[WE_SW];

  always_comb begin
    strb          = 4'hF;
    wdata_aligned = wdata;
    misalign      = 1'b0;
    if (is_sw) begin
      misalign = (addr != 2'b00);
    end else if (is_sh) begin
      strb          = 4'b0011 << {addr[1], 1'b0};
      wdata_aligned = {2{wdata[15:0]}};
      misalign      = addr[0];
    end else if (is_sb) begin
      strb          = 4'b0001 << addr;
      wdata_aligned = {4{wdata[7:0]}};
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's flat single-cycle data-memory port onto a word-addressed
// req/ack bus with byte strobes, wait states, misalignment and timeout flags.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AWIDTH  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phase_memoryaccess,
  input  logic [AWIDTH-1:0] data_mem_addr,
  input  logic [XLEN-1:0]   data_mem_wdata,
  input  logic [2:0]        data_mem_we,
  output logic [XLEN-1:0]   data_mem_out,
  output logic              mem_busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AWIDTH-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [3:0]        bus_strb,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  output logic              err_misalign,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] timer;
  logic [3:0]      lane_strb;
  logic [XLEN-1:0] lane_wdata;
  logic            lane_misalign;

  dmem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .addr          (data_mem_addr[1:0]),
    .we            (data_mem_we),
    .wdata         (data_mem_wdata),
    .strb          (lane_strb),
    .wdata_aligned (lane_wdata),
    .misalign      (lane_misalign)
  );

  // Bus fields are captured once at launch and held untouched for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      data_mem_out <= '0;
      mem_busy     <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_strb     <= 4'h0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (phase_memoryaccess) begin
            if (lane_misalign) begin
              err_misalign <= 1'b1;
            end else begin
              state     <= ST_REQ;
              timer     <= '0;
              mem_busy  <= 1'b1;
              bus_req   <= 1'b1;
              bus_we    <= (data_mem_we != 3'b000);
              bus_addr  <= {data_mem_addr[AWIDTH-1:2], 2'b00};
              bus_wdata <= lane_wdata;
              bus_strb  <= lane_strb;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              data_mem_out <= bus_rdata;
            end
            state    <= ST_IDLE;
            mem_busy <= 1'b0;
            bus_req  <= 1'b0;
          end else if (timer == TO_LAST) begin
            state       <= ST_IDLE;
            mem_busy    <= 1'b0;
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_busy <= 1'b0;
          bus_req  <= 1'b0;
        end
      endcase
      // A clear in the same cycle as a new error wins.
      if (err_clr) begin
        err_misalign <= 1'b0;
        err_timeout  <= 1'b0;
      end
    end
  end

endmodule
